// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard
// Bypass and hazard controller sitting at the ID/EX boundary. Tracks the
// in-flight writers of the last DEPTH advancing cycles in a shift register and,
// for each source operand of the issuing instruction, picks the youngest
// in-flight producer of that register. A ready producer is forwarded from its
// stage. A producer that is not ready yet raises a stall.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset (clears all entries and the counter)
//   hold         global freeze: no shift, no load, counter frozen
//   issue_valid  instruction present at ID/EX
//   issue_wen    issuing instruction writes issue_rd
//   issue_rd     destination register of the issuing instruction
//   issue_lat    cycles after issue until the result reaches a bypass path
//   src_rs       packed source registers, field i = [i*REG_AW +: REG_AW]
//   src_used     source i is actually read
//   fwd_sel      per-source select: 0 = regfile, k = bypass from stage k
//   stall        issuing instruction must wait; a bubble enters stage 1
//   stall_count  saturating count of cycles with stall=1 and hold=0
module fwd_scoreboard #(
  parameter int DEPTH   = 2,
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int LAT_W   = 2,
  parameter int SEL_W   = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hold,
  input  logic                       issue_valid,
  input  logic                       issue_wen,
  input  logic [REG_AW-1:0]          issue_rd,
  input  logic [LAT_W-1:0]           issue_lat,
  input  logic [NUM_SRC*REG_AW-1:0]  src_rs,
  input  logic [NUM_SRC-1:0]         src_used,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
  output logic                       stall,
  output logic [31:0]                stall_count
);

  // In-flight writer entries, stage 1 (youngest) .. DEPTH (oldest)
  logic              v_r   [1:DEPTH];
  logic [REG_AW-1:0] rd_r  [1:DEPTH];
  logic [SEL_W-1:0]  lat_r [1:DEPTH];
  logic [31:0]       stall_count_r;

  logic [SEL_W-1:0]         eff_lat_s;
  logic [DEPTH:1]           match_s   [NUM_SRC];
  logic [NUM_SRC-1:0]       hit_s;
  logic [SEL_W-1:0]         hit_k_s   [NUM_SRC];
  logic [SEL_W-1:0]         hit_lat_s [NUM_SRC];
  logic [NUM_SRC-1:0]       hazard_s;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_s;
  logic                     stall_s;
  logic                     load_s;

  // Normalise the issue latency into 1..DEPTH: zero means one cycle, and a
  // producer slower than the bypass window is ready at the last stage anyway.
  always_comb begin
    eff_lat_s = SEL_W'(32'd1);
    if (issue_lat == {LAT_W{1'b0}}) begin
      eff_lat_s = SEL_W'(32'd1);
    end else if (32'(issue_lat) > 32'(DEPTH)) begin
      eff_lat_s = SEL_W'(DEPTH);
    end else begin
      eff_lat_s = SEL_W'(issue_lat);
    end
  end

  // Per source and stage: does that stage hold a live writer of this source?
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      match_s[i] = '0;
      for (int k = 1; k <= DEPTH; k++) begin
        match_s[i][k] = src_used[i] && v_r[k] &&
                        (rd_r[k] == src_rs[i*REG_AW +: REG_AW]) &&
                        (src_rs[i*REG_AW +: REG_AW] != {REG_AW{1'b0}});
      end
    end
  end

  // Youngest match wins; it is forwarded only if it has reached its latency,
  // otherwise the source is a hazard (an older ready copy must not mask it).
  always_comb begin
    hit_s     = '0;
    fwd_sel_s = '0;
    hazard_s  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hit_k_s[i]   = '0;
      hit_lat_s[i] = '0;
      // Scan oldest to youngest so the youngest match overwrites the rest.
      for (int k = DEPTH; k >= 1; k--) begin
        hit_s[i]     = match_s[i][k] | hit_s[i];
        hit_k_s[i]   = match_s[i][k] ? SEL_W'(k) : hit_k_s[i];
        hit_lat_s[i] = match_s[i][k] ? lat_r[k]  : hit_lat_s[i];
      end
      if (!hit_s[i]) begin
        fwd_sel_s[i*SEL_W +: SEL_W] = '0;
      end else if (hit_k_s[i] >= hit_lat_s[i]) begin
        fwd_sel_s[i*SEL_W +: SEL_W] = hit_k_s[i];
      end else begin
        hazard_s[i] = 1'b1;
      end
    end
    stall_s = issue_valid & (|hazard_s);
    load_s  = issue_valid & ~stall_s & issue_wen & (issue_rd != {REG_AW{1'b0}});
  end

  // Shift register of in-flight writers; a stalled or idle slot enters as a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) begin
        v_r[k]   <= 1'b0;
        rd_r[k]  <= '0;
        lat_r[k] <= '0;
      end
    end else if (!hold) begin
      for (int k = DEPTH; k >= 2; k--) begin
        v_r[k]   <= v_r[k-1];
        rd_r[k]  <= rd_r[k-1];
        lat_r[k] <= lat_r[k-1];
      end
      v_r[1]   <= load_s;
      rd_r[1]  <= issue_rd;
      lat_r[1] <= eff_lat_s;
    end
  end

  // Saturating stall-cycle counter; frozen during hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_r <= 32'd0;
    end else if (stall_s && !hold && (stall_count_r != 32'hFFFF_FFFF)) begin
      stall_count_r <= stall_count_r + 32'd1;
    end
  end

  assign fwd_sel     = fwd_sel_s;
  assign stall       = stall_s;
  assign stall_count = stall_count_r;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard. Two instances (DEPTH=2 and DEPTH=4)
// share the same stimulus. The reference model keeps a log of accepted writers
// stamped with the advance count at issue; a writer's stage is its age in
// advancing cycles.
module tb_fwd_scoreboard;
  localparam int NS  = 2;
  localparam int AW  = 5;
  localparam int LW  = 2;
  localparam int SW2 = 2;
  localparam int SW4 = 3;

  logic clk = 1'b0;
  logic rst, hold, issue_valid, issue_wen;
  logic [AW-1:0]    issue_rd;
  logic [LW-1:0]    issue_lat;
  logic [NS*AW-1:0] src_rs;
  logic [NS-1:0]    src_used;
  logic [NS*SW2-1:0] fwd_sel2;
  logic [NS*SW4-1:0] fwd_sel4;
  logic stall2, stall4;
  logic [31:0] cnt2, cnt4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fwd_scoreboard #(.DEPTH(2), .NUM_SRC(NS), .REG_AW(AW), .LAT_W(LW)) dut2 (
    .clk(clk), .rst(rst), .hold(hold), .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_rd(issue_rd), .issue_lat(issue_lat), .src_rs(src_rs), .src_used(src_used),
    .fwd_sel(fwd_sel2), .stall(stall2), .stall_count(cnt2));

  fwd_scoreboard #(.DEPTH(4), .NUM_SRC(NS), .REG_AW(AW), .LAT_W(LW)) dut4 (
    .clk(clk), .rst(rst), .hold(hold), .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_rd(issue_rd), .issue_lat(issue_lat), .src_rs(src_rs), .src_used(src_used),
    .fwd_sel(fwd_sel4), .stall(stall4), .stall_count(cnt4));

  // ---------------- reference model (index 0: DEPTH=2, 1: DEPTH=4) ----------
  bit          rec_ok  [2][64];
  int          rec_rd  [2][64];
  int          rec_lat [2][64];
  int          rec_t   [2][64];
  int          adv     [2];
  int          nrec    [2];
  logic [31:0] m_cnt   [2];
  int          m_sel   [2][NS];
  bit          m_stall [2];
  logic [NS*SW2-1:0] exp_sel2;
  logic [NS*SW4-1:0] exp_sel4;

  function automatic int depth_of(int m);
    return (m == 0) ? 2 : 4;
  endfunction

  function automatic int eff_lat(int l, int d);
    if (l == 0) return 1;
    if (l > d) return d;
    return l;
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int j = 0; j < 64; j++) rec_ok[m][j] = 1'b0;
      m_cnt[m] = 32'd0;
    end
  endfunction

  function automatic void model_eval();
    for (int m = 0; m < 2; m++) begin
      bit hz;
      hz = 1'b0;
      for (int i = 0; i < NS; i++) begin
        int rs, best, blat, age;
        rs = int'(src_rs[i*AW +: AW]);
        best = 0;
        blat = 0;
        m_sel[m][i] = 0;
        if (src_used[i] && rs != 0) begin
          for (int j = 0; j < 64; j++) begin
            age = adv[m] - rec_t[m][j];
            if (rec_ok[m][j] && rec_rd[m][j] == rs && age >= 1 && age <= depth_of(m) &&
                (best == 0 || age < best)) begin
              best = age;
              blat = rec_lat[m][j];
            end
          end
        end
        if (best != 0) begin
          if (best >= blat) m_sel[m][i] = best;
          else hz = 1'b1;
        end
      end
      m_stall[m] = issue_valid && hz;
    end
    exp_sel2 = '0;
    exp_sel4 = '0;
    for (int i = 0; i < NS; i++) begin
      exp_sel2[i*SW2 +: SW2] = SW2'(m_sel[0][i]);
      exp_sel4[i*SW4 +: SW4] = SW4'(m_sel[1][i]);
    end
  endfunction

  function automatic void model_clock();
    if (!rst && !hold) begin
      for (int m = 0; m < 2; m++) begin
        if (m_stall[m] && m_cnt[m] != 32'hFFFF_FFFF) m_cnt[m] = m_cnt[m] + 32'd1;
        if (issue_valid && !m_stall[m] && issue_wen && issue_rd != 5'd0) begin
          rec_ok[m][nrec[m] % 64]  = 1'b1;
          rec_rd[m][nrec[m] % 64]  = int'(issue_rd);
          rec_lat[m][nrec[m] % 64] = eff_lat(int'(issue_lat), depth_of(m));
          rec_t[m][nrec[m] % 64]   = adv[m];
          nrec[m]++;
        end
        adv[m]++;
      end
    end
  endfunction

  // ---------------- stimulus helpers ----------------------------------------
  task automatic drive(input bit iv, input bit wen, input int rd, input int lat,
                       input int rs0, input int rs1, input int used);
    issue_valid = iv;
    issue_wen   = wen;
    issue_rd    = AW'(rd);
    issue_lat   = LW'(lat);
    src_rs      = {AW'(rs1), AW'(rs0)};
    src_used    = NS'(used);
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic flush();
    hold = 1'b0;
    drive(1'b0, 1'b0, 0, 1, 0, 0, 0);
    repeat (5) step();
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    hold = 1'b0;
    drive(1'b1, 1'b1, 5, 1, 5, 5, 3);
    model_reset();
    settle();
    if ({fwd_sel2, stall2, cnt2, fwd_sel4, stall4, cnt4} !== '0) begin
      failures++;
      $display("FAIL reset got sel2=%h st2=%b c2=%h sel4=%h st4=%b c4=%h want all zero",
               fwd_sel2, stall2, cnt2, fwd_sel4, stall4, cnt4);
    end
    checks++;
    step();
    rst = 1'b0;
    flush();
  endtask

  task automatic test_alu_forward();
    int rd[4]  = '{5, 6, 8, 9};
    int rs0[4] = '{0, 5, 0, 5};
    int rs1[4] = '{0, 0, 5, 5};
    int us[4]  = '{0, 1, 2, 3};
    logic [3:0] c2[4] = '{4'h0, 4'h1, 4'h8, 4'h0};
    flush();
    for (int r = 0; r < 4; r++) begin
      drive(1'b1, 1'b1, rd[r], 1, rs0[r], rs1[r], us[r]);
      settle();
      if ({fwd_sel2, stall2} !== {c2[r], 1'b0} || {fwd_sel2, stall2} !== {exp_sel2, m_stall[0]}) begin
        failures++;
        $display("FAIL alu_fwd[%0d] d2 got sel=%h stall=%b want sel=%h stall=0", r, fwd_sel2, stall2, c2[r]);
      end
      checks++;
      if ({fwd_sel4, stall4, cnt4} !== {exp_sel4, m_stall[1], m_cnt[1]}) begin
        failures++;
        $display("FAIL alu_fwd[%0d] d4 got sel=%h stall=%b want sel=%h stall=%b", r, fwd_sel4, stall4, exp_sel4, m_stall[1]);
      end
      checks++;
      step();
    end
  endtask

  task automatic test_load_use();
    logic [31:0] base2;
    int rd[3]  = '{7, 10, 10};
    int lat[3] = '{2, 1, 1};
    int rs0[3] = '{0, 7, 7};
    int us[3]  = '{0, 1, 1};
    bit cst[3] = '{1'b0, 1'b1, 1'b0};
    logic [3:0] c2[3] = '{4'h0, 4'h0, 4'h2};
    flush();
    base2 = cnt2;
    for (int r = 0; r < 3; r++) begin
      drive(1'b1, 1'b1, rd[r], lat[r], rs0[r], 0, us[r]);
      settle();
      if ({fwd_sel2, stall2} !== {c2[r], cst[r]} || cnt2 - base2 !== ((r == 2) ? 32'd1 : 32'd0)) begin
        failures++;
        $display("FAIL load_use[%0d] d2 got sel=%h stall=%b dcnt=%0d want sel=%h stall=%b", r, fwd_sel2, stall2, cnt2 - base2, c2[r], cst[r]);
      end
      checks++;
      if ({fwd_sel4, stall4, cnt4} !== {exp_sel4, m_stall[1], m_cnt[1]}) begin
        failures++;
        $display("FAIL load_use[%0d] d4 got sel=%h stall=%b cnt=%h want sel=%h stall=%b cnt=%h", r, fwd_sel4, stall4, cnt4, exp_sel4, m_stall[1], m_cnt[1]);
      end
      checks++;
      step();
    end
  endtask

  task automatic test_multi_stage();
    int rd[6]  = '{3, 3, 11, 0, 3, 12};
    int lat[6] = '{1, 1, 1, 1, 2, 1};
    int rs[6]  = '{0, 0, 3, 3, 0, 3};
    int us[6]  = '{0, 0, 3, 0, 3, 0};
    bit wen[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] c2[6] = '{4'h0, 4'h0, 4'h5, 4'h0, 4'h0, 4'h0};
    flush();
    for (int r = 0; r < 6; r++) begin
      drive(1'b1, wen[r], rd[r], lat[r], rs[r], rs[r], us[r]);
      settle();
      if ({fwd_sel2, stall2} !== {c2[r], 1'b0} || {fwd_sel2, stall2, cnt2} !== {exp_sel2, m_stall[0], m_cnt[0]}) begin
        failures++;
        $display("FAIL multi[%0d] d2 got sel=%h stall=%b want sel=%h stall=0", r, fwd_sel2, stall2, c2[r]);
      end
      checks++;
      if ({fwd_sel4, stall4, cnt4} !== {exp_sel4, m_stall[1], m_cnt[1]}) begin
        failures++;
        $display("FAIL multi[%0d] d4 got sel=%h stall=%b want sel=%h stall=%b", r, fwd_sel4, stall4, exp_sel4, m_stall[1]);
      end
      checks++;
      step();
    end
  endtask

  task automatic test_long_latency();
    logic [31:0] base4;
    bit hl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    bit st4[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [5:0] c4[6] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h03};
    logic [31:0] d4[6] = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd2};
    flush();
    base4 = cnt4;
    for (int r = 0; r < 6; r++) begin
      if (r == 0) drive(1'b1, 1'b1, 9, 3, 0, 0, 0);
      else drive(1'b1, 1'b1, 11, 1, 9, 0, 1);
      hold = hl[r];
      settle();
      if ({fwd_sel4, stall4} !== {c4[r], st4[r]} || cnt4 - base4 !== d4[r] ||
          {fwd_sel4, stall4, cnt4} !== {exp_sel4, m_stall[1], m_cnt[1]}) begin
        failures++;
        $display("FAIL long_lat[%0d] d4 got sel=%h stall=%b dcnt=%0d want sel=%h stall=%b dcnt=%0d", r, fwd_sel4, stall4, cnt4 - base4, c4[r], st4[r], d4[r]);
      end
      checks++;
      if ({fwd_sel2, stall2, cnt2} !== {exp_sel2, m_stall[0], m_cnt[0]} || (r == 4 && fwd_sel2 !== 4'h2)) begin
        failures++;
        $display("FAIL long_lat[%0d] d2 got sel=%h stall=%b cnt=%h want sel=%h stall=%b cnt=%h", r, fwd_sel2, stall2, cnt2, exp_sel2, m_stall[0], m_cnt[0]);
      end
      checks++;
      step();
    end
    hold = 1'b0;
  endtask

  task automatic test_lat_zero();
    flush();
    drive(1'b1, 1'b1, 12, 0, 0, 0, 0);
    step();
    drive(1'b1, 1'b1, 13, 1, 0, 12, 2);
    settle();
    if ({fwd_sel2, stall2} !== {4'h4, 1'b0} || {fwd_sel4, stall4} !== {6'h08, 1'b0}) begin
      failures++;
      $display("FAIL lat_zero got sel2=%h st2=%b sel4=%h st4=%b want sel2=4 sel4=08 no stall", fwd_sel2, stall2, fwd_sel4, stall4);
    end
    checks++;
    step();
  endtask

  task automatic test_saturation();
    flush();
    force dut2.stall_count_r = 32'hFFFF_FFFD;
    force dut4.stall_count_r = 32'hFFFF_FFFD;
    #1;
    release dut2.stall_count_r;
    release dut4.stall_count_r;
    m_cnt[0] = 32'hFFFF_FFFD;
    m_cnt[1] = 32'hFFFF_FFFD;
    for (int p = 0; p < 4; p++) begin
      drive(1'b1, 1'b1, 13, 3, 0, 0, 0);
      step();
      for (int c = 0; c < 3; c++) begin
        drive(1'b1, 1'b1, 14, 1, 13, 13, 3);
        settle();
        if ({fwd_sel2, stall2, cnt2, fwd_sel4, stall4, cnt4} !==
            {exp_sel2, m_stall[0], m_cnt[0], exp_sel4, m_stall[1], m_cnt[1]}) begin
          failures++;
          $display("FAIL sat[%0d.%0d] got c2=%h st2=%b c4=%h st4=%b want c2=%h st2=%b c4=%h st4=%b", p, c, cnt2, stall2, cnt4, stall4, m_cnt[0], m_stall[0], m_cnt[1], m_stall[1]);
        end
        checks++;
        step();
      end
    end
    if (cnt2 !== 32'hFFFF_FFFF || cnt4 !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL sat_final got c2=%h c4=%h want ffffffff", cnt2, cnt4);
    end
    checks++;
  endtask

  task automatic test_async_reset();
    flush();
    drive(1'b1, 1'b1, 14, 2, 0, 0, 0);
    step();
    drive(1'b1, 1'b1, 15, 1, 14, 0, 1);
    settle();
    if (stall2 !== 1'b1 || stall4 !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre got st2=%b st4=%b want 1 1", stall2, stall4);
    end
    checks++;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    model_eval();
    if ({fwd_sel2, stall2, cnt2, fwd_sel4, stall4, cnt4} !== '0) begin
      failures++;
      $display("FAIL arst_now got sel2=%h st2=%b c2=%h sel4=%h st4=%b c4=%h want all zero", fwd_sel2, stall2, cnt2, fwd_sel4, stall4, cnt4);
    end
    checks++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    settle();
    if ({fwd_sel2, stall2, fwd_sel4, stall4} !== '0 || {fwd_sel2, stall2} !== {exp_sel2, m_stall[0]}) begin
      failures++;
      $display("FAIL arst_after got sel2=%h st2=%b sel4=%h st4=%b want zero", fwd_sel2, stall2, fwd_sel4, stall4);
    end
    checks++;
    step();
  endtask

  task automatic test_random();
    flush();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 6),
            $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 3));
      hold = ($urandom_range(0, 7) == 0);
      settle();
      if ({fwd_sel2, stall2, cnt2} !== {exp_sel2, m_stall[0], m_cnt[0]}) begin
        failures++;
        $display("FAIL rand[%0d] d2 got sel=%h stall=%b cnt=%h want sel=%h stall=%b cnt=%h", n, fwd_sel2, stall2, cnt2, exp_sel2, m_stall[0], m_cnt[0]);
      end
      checks++;
      if ({fwd_sel4, stall4, cnt4} !== {exp_sel4, m_stall[1], m_cnt[1]}) begin
        failures++;
        $display("FAIL rand[%0d] d4 got sel=%h stall=%b cnt=%h want sel=%h stall=%b cnt=%h", n, fwd_sel4, stall4, cnt4, exp_sel4, m_stall[1], m_cnt[1]);
      end
      checks++;
      step();
    end
    hold = 1'b0;
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      adv[m]  = 100;
      nrec[m] = 0;
    end
    test_reset();
    test_alu_forward();
    test_load_use();
    test_multi_stage();
    test_long_latency();
    test_lat_zero();
    test_saturation();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised bypass and hazard controller for the pipelined RISC-V core. It generalises the fixed two-stage forwarding decision to a configurable number of bypass stages and source operands, and to multi-cycle producers. Internally it tracks in-flight writers in a shift register and drives a per-source bypass-stage select, a load-use/latency stall, and a saturating stall-cycle counter. It sits at the ID/EX boundary: it sees the issuing instruction's sources, destination and latency, and its select outputs drive the EX operand muxes.

## Interface
Parameters:
- DEPTH, 2, number of forwardable in-flight stages (stage 1 = EX/MEM-equivalent, stage DEPTH = last before regfile write)
- NUM_SRC, 2, source operands checked per issuing instruction
- REG_AW, 5, register address width; register 0 is hardwired zero
- LAT_W, 2, width of issue_lat
- SEL_W, clog2(DEPTH+1), width of one select field

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- hold  in  1  global freeze (e.g. memory stall); shift register and counter do not advance
- issue_valid  in  1  instruction present at ID/EX
- issue_wen  in  1  instruction writes issue_rd
- issue_rd  in  REG_AW  destination register
- issue_lat  in  LAT_W  cycles after issue until result is on a bypass path (ALU=1, load=2)
- src_rs  in  NUM_SRC*REG_AW  packed source registers, field i = bits [i*REG_AW +: REG_AW]
- src_used  in  NUM_SRC  source i is actually read
- fwd_sel  out  NUM_SRC*SEL_W  per-source select: 0 = regfile, k = bypass from stage k
- stall  out  1  issuing instruction must wait; bubble inserted
- stall_count  out  32  saturating count of cycles with stall=1 and hold=0

## Operation
- State: DEPTH entries {v, rd, lat}, stage 1..DEPTH. Entry at stage k belongs to the instruction issued k advancing cycles ago.
- Entry written only when issue_valid && issue_wen && issue_rd != 0; otherwise a bubble (v=0) enters stage 1.
- Effective latency: issue_lat==0 is treated as 1; issue_lat>DEPTH is clamped to DEPTH.
- Per source i, match(k) = src_used[i] && v[k] && rd[k]==src_rs[i] && src_rs[i]!=0.
- The youngest match k* (smallest k) wins. If there is no match, fwd_sel[i]=0.
- If k* >= lat[k*], fwd_sel[i]=k*. Otherwise the producer is not ready: fwd_sel[i]=0 and the source raises a hazard.
- An older ready match never masks a younger unready one.
- stall = issue_valid && OR of source hazards. Fully combinational from state and inputs.
- Advance (hold=0): entries shift k→k+1 and stage DEPTH drops out (its value is in the regfile by then). Stage 1 loads the issuing instruction if issue_valid && !stall, else a bubble.
- hold=1: no shift, no load, stall_count frozen. fwd_sel and stall are still computed from the frozen state.
- stall_count increments when stall && !hold. It saturates at 0xFFFFFFFF without wrapping.

## Timing
- Reset (async, immediate): all v=0, stall_count=0. Hence fwd_sel all 0 and stall=0 while rst is high and after release.
- fwd_sel/stall: zero-latency combinational path from src_rs/src_used/issue_valid and registered state.
- Issue accepted at a rising edge with issue_valid && !stall && !hold. Producer visible at stage 1 in the following cycle.
- Load-use (lat=2) with an immediate consumer: exactly 1 stall cycle, then fwd_sel=2. With lat=L, the stall lasts L-1 cycles for an adjacent consumer.
- Simultaneous same rd in multiple stages: youngest stage is selected.
- A producer and consumer with the same register in the same issuing instruction (rd==rs): the check uses older entries only; no self-match.
- Reset mid-stall clears all entries. The pending consumer proceeds with fwd_sel=0 after reset.

## Test plan
- DEPTH=2: issue ADD x5 (lat1), then SUB rs1=x5 → fwd_sel[0]=1, stall=0. One instruction later, rs2=x5 → fwd_sel[1]=2. Two later → 0.
- Load x7 (lat2), then consumer rs1=x7 → stall=1 for 1 cycle with a bubble in stage 1; next cycle fwd_sel[0]=2, stall=0; stall_count=1.
- Writes to x3 at stages 1 and 2 (both lat1), consumer rs1=rs2=x3 → both fields=1. Use rd=x0 with src x0 → fields 0, no stall. src_used=0 with a matching rs → 0, no stall.
- DEPTH=4, lat=3 producer x9 followed by an adjacent consumer → 2 stall cycles, then fwd_sel=3. hold=1 during the stall → state frozen, stall held, stall_count unchanged.
- issue_lat=0 behaves as 1. issue_lat=3 with DEPTH=2 is clamped to 2. stall_count preloaded near max via a long stall → stops at 0xFFFFFFFF.
- Assert rst asynchronously mid-stall (between edges) → stall and fwd_sel drop to 0 immediately; stall_count=0.
